// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register: state encoding
// and the EX/MEM control-bundle layout used by stage instantiators.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  // EX/MEM instance geometry
  localparam int EXMEM_DATA_W = 101;
  localparam int EXMEM_CTRL_W = 10;

  // EX/MEM control-bundle bit positions
  localparam int EXMEM_REG_WRITE     = 9;
  localparam int EXMEM_MEM_TO_REG_HI = 8;
  localparam int EXMEM_MEM_TO_REG_LO = 7;
  localparam int EXMEM_MEM_READ      = 6;
  localparam int EXMEM_MEM_WRITE     = 5;
  localparam int EXMEM_PC_SRC_HI     = 4;
  localparam int EXMEM_PC_SRC_LO     = 3;
  localparam int EXMEM_JUMP          = 2;
  localparam int EXMEM_BRANCH        = 1;
  localparam int EXMEM_ALU_ZERO      = 0;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic pipeline-stage register with valid/ready handshake, a one-entry skid
// buffer so in_ready_o is a pure state decode, and a synchronous flush.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 10,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a transfer happens on an edge where valid & ready are both 1;
  // producers hold data while valid & !ready, and ready never looks at valid.

  pipe_state_e       r_state;
  pipe_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;

  logic w_push;
  logic w_pop;
  logic w_ld_main_in;
  logic w_ld_main_skid;
  logic w_ld_skid;

  assign w_push = in_valid_i & in_ready_o;
  assign w_pop  = out_valid_o & out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) begin
            w_state_nxt  = ST_ONE;
            w_ld_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_push && !w_pop) begin
            w_state_nxt = ST_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_push && w_pop) begin
            w_ld_main_in = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            w_state_nxt    = ST_ONE;
            w_ld_main_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Unused encodings report as not-ready and not-valid until recovered.
  always_comb begin
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    occupancy_o = 2'd0;
    case (r_state)
      ST_EMPTY: begin
        in_ready_o = 1'b1;
      end
      ST_ONE: begin
        in_ready_o  = 1'b1;
        out_valid_o = 1'b1;
        occupancy_o = 2'd1;
      end
      ST_FULL: begin
        out_valid_o = 1'b1;
        occupancy_o = 2'd2;
      end
      default: begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        occupancy_o = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= '0;
      r_main_ctrl <= '0;
      r_skid_data <= '0;
      r_skid_ctrl <= '0;
    end else if (flush_i) begin
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      if (CLEAR_DATA) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else begin
      if (w_ld_main_in) begin
        r_main_data <= in_data_i;
        r_main_ctrl <= in_ctrl_i;
      end else if (w_ld_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_ctrl <= r_skid_ctrl;
      end
      if (w_ld_skid) begin
        r_skid_data <= in_data_i;
        r_skid_ctrl <= in_ctrl_i;
      end
    end
  end

  // Bubbles are NOPs: control always masked, payload masked only when asked.
  assign out_ctrl_o  = out_valid_o ? r_main_ctrl : '0;
  assign out_data_o  = (CLEAR_DATA && !out_valid_o) ? '0 : r_main_data;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, back-pressure, flush,
// plus a CLEAR_DATA=0 instance sharing the same stimulus.
module tb_pipe_skid_reg;

  localparam int DW = 32;
  localparam int CW = 10;

  logic          clk;
  logic          rst_n;
  logic          flush_i;
  logic          in_valid_i;
  logic [DW-1:0] in_data_i;
  logic [CW-1:0] in_ctrl_i;
  logic          out_ready_i;

  logic          in_ready_o,  in_ready_nc;
  logic          out_valid_o, out_valid_nc;
  logic [DW-1:0] out_data_o,  out_data_nc;
  logic [CW-1:0] out_ctrl_o,  out_ctrl_nc;
  logic [1:0]    occupancy_o, occupancy_nc;
  logic [1:0]    dbg_state_o, dbg_state_nc;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_ctrl_o(out_ctrl_o),
    .occupancy_o(occupancy_o), .dbg_state_o(dbg_state_o)
  );

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CLEAR_DATA(1'b0)) u_dut_nc (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_nc),
    .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(out_valid_nc), .out_ready_i(out_ready_i),
    .out_data_o(out_data_nc), .out_ctrl_o(out_ctrl_nc),
    .occupancy_o(occupancy_nc), .dbg_state_o(dbg_state_nc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid_i = v;
    in_data_i  = d;
    in_ctrl_i  = c;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [DW-1:0] d,
                            input logic [CW-1:0] c, input logic [1:0] occ, input logic rdy);
    check({tag, ".valid"}, 64'(out_valid_o), 64'(v));
    check({tag, ".data"},  64'(out_data_o),  64'(d));
    check({tag, ".ctrl"},  64'(out_ctrl_o),  64'(c));
    check({tag, ".occ"},   64'(occupancy_o), 64'(occ));
    check({tag, ".ready"}, 64'(in_ready_o),  64'(rdy));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b0;
    drive(1'b0, '0, '0);

    // 1. reset values
    #12;
    expect_out("rst", 1'b0, 32'h0, 10'h0, 2'd0, 1'b1);
    check("rst.state", 64'(dbg_state_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. streaming with out_ready high
    out_ready_i = 1'b1;
    drive(1'b1, 32'h8, 10'h201);
    step();
    expect_out("s0", 1'b1, 32'h8, 10'h201, 2'd1, 1'b1);
    drive(1'b1, 32'h14, 10'h010);
    step();
    expect_out("s1", 1'b1, 32'h14, 10'h010, 2'd1, 1'b1);
    drive(1'b1, 32'h18, 10'h207);
    step();
    expect_out("s2", 1'b1, 32'h18, 10'h207, 2'd1, 1'b1);
    drive(1'b0, 32'h55, 10'h3ff);
    step();
    expect_out("s3", 1'b0, 32'h0, 10'h0, 2'd0, 1'b1);

    // 3. back-pressure into the skid entry
    out_ready_i = 1'b0;
    drive(1'b1, 32'hA, 10'h001);
    step();
    expect_out("bp0", 1'b1, 32'hA, 10'h001, 2'd1, 1'b1);
    drive(1'b1, 32'hB, 10'h002);
    step();
    expect_out("bp1", 1'b1, 32'hA, 10'h001, 2'd2, 1'b0);
    drive(1'b1, 32'hC, 10'h003);
    step();
    expect_out("bp2", 1'b1, 32'hA, 10'h001, 2'd2, 1'b0);
    drive(1'b0, '0, '0);
    out_ready_i = 1'b1;
    #1;
    check("bp.ready_indep", 64'(in_ready_o), 64'd0);
    step();
    expect_out("bp3", 1'b1, 32'hB, 10'h002, 2'd1, 1'b1);
    step();
    expect_out("bp4", 1'b0, 32'h0, 10'h0, 2'd0, 1'b1);

    // 4. simultaneous push and pop in ONE
    drive(1'b1, 32'h20, 10'h004);
    step();
    expect_out("pp0", 1'b1, 32'h20, 10'h004, 2'd1, 1'b1);
    drive(1'b1, 32'h2C, 10'h005);
    step();
    expect_out("pp1", 1'b1, 32'h2C, 10'h005, 2'd1, 1'b1);
    drive(1'b0, '0, '0);
    step();
    expect_out("pp2", 1'b0, 32'h0, 10'h0, 2'd0, 1'b1);

    // 5. flush while FULL, then a normal push
    out_ready_i = 1'b0;
    drive(1'b1, 32'h1, 10'h011);
    step();
    drive(1'b1, 32'h2, 10'h012);
    step();
    check("fl.pre_occ", 64'(occupancy_o), 64'd2);
    flush_i = 1'b1;
    drive(1'b1, 32'hEEEEEEEE, 10'h3ff);
    step();
    expect_out("fl0", 1'b0, 32'h0, 10'h0, 2'd0, 1'b1);
    flush_i = 1'b0;
    drive(1'b1, 32'hDDDDDDDD, 10'h006);
    step();
    expect_out("fl1", 1'b1, 32'hDDDDDDDD, 10'h006, 2'd1, 1'b1);
    // flush in ONE discards the concurrent push
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    drive(1'b1, 32'h77, 10'h007);
    step();
    expect_out("fl2", 1'b0, 32'h0, 10'h0, 2'd0, 1'b1);
    flush_i = 1'b0;
    drive(1'b0, '0, '0);
    step();
    expect_out("fl3", 1'b0, 32'h0, 10'h0, 2'd0, 1'b1);

    // 6. CLEAR_DATA=0 keeps the payload across a flush
    out_ready_i = 1'b0;
    drive(1'b1, 32'h1234, 10'h00f);
    step();
    check("nc.pre_data", 64'(out_data_nc), 64'h1234);
    drive(1'b0, '0, '0);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("nc.valid", 64'(out_valid_nc), 64'd0);
    check("nc.ctrl",  64'(out_ctrl_nc),  64'd0);
    check("nc.data",  64'(out_data_nc),  64'h1234);
    check("nc.ready", 64'(in_ready_nc),  64'd1);
    check("cd.data",  64'(out_data_o),   64'h0);

    // 1b. asynchronous reset mid-stream with two entries held
    drive(1'b1, 32'h31, 10'h021);
    step();
    drive(1'b1, 32'h32, 10'h022);
    step();
    drive(1'b0, '0, '0);
    check("ar.pre_occ", 64'(occupancy_o), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("ar", 1'b0, 32'h0, 10'h0, 2'd0, 1'b1);
    check("ar.nc_data", 64'(out_data_nc), 64'h0);
    check("ar.nc_occ",  64'(occupancy_nc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // skid contents were cleared: a new entry passes through untouched
    out_ready_i = 1'b1;
    drive(1'b1, 32'h99, 10'h009);
    step();
    expect_out("ar.post", 1'b1, 32'h99, 10'h009, 2'd1, 1'b1);
    drive(1'b0, '0, '0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline-stage register with valid/ready handshake, a one-entry skid buffer and synchronous flush.
- Replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with a single generic block.
- Adds back-pressure (stall) without a combinational ready path; ordering is preserved.
- Flush and bubbles drive control to zero, so a bubble is a NOP.
- EX/MEM instance: DATA_W=101 (pc+4, alu result, rs2 data, rd), CTRL_W=10 (reg_write, mem_to_reg[2], mem_read, mem_write, pc_src[2], jump, branch, alu_zero).

Parameters:
DATA_W, 32, payload width (datapath fields, concatenated by the instantiator).
CTRL_W, 10, control bundle width; forced to 0 on flush and whenever no valid entry is present.
CLEAR_DATA, 1, 1 = payload also zeroed on flush/bubble; 0 = payload holds its last value (saves area).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush_i  in  1  synchronous flush; highest priority.
in_valid_i  in  1  upstream entry valid.
in_ready_o  out  1  stage can accept; registered.
in_data_i  in  DATA_W  upstream payload.
in_ctrl_i  in  CTRL_W  upstream control bundle.
out_valid_o  out  1  downstream entry valid; registered.
out_ready_i  in  1  downstream accepts.
out_data_o  out  DATA_W  payload of the head entry.
out_ctrl_o  out  CTRL_W  control of the head entry; 0 when out_valid_o=0.
occupancy_o  out  2  entries held: 0, 1 or 2.

Behaviour:
- push = in_valid_i & in_ready_o. pop = out_valid_o & out_ready_i.
- Storage: main entry (drives the outputs) and skid entry. States, encoding in the package:
  - EMPTY = 0 entries.
  - ONE = main only.
  - FULL = main and skid.
- Transitions when flush_i=0:
  - EMPTY: push -> ONE, main<=in.
  - ONE: push&!pop -> FULL, skid<=in. push&pop -> ONE, main<=in. !push&pop -> EMPTY. Neither -> hold.
  - FULL: pop -> ONE, main<=skid. No push is possible. No pop -> hold all contents.
- Output and status values per state:
  - in_ready_o = 1 in EMPTY/ONE, 0 in FULL. It is a state decode only and never depends on out_ready_i or in_valid_i.
  - out_valid_o = 1 in ONE/FULL.
  - occupancy_o = 0/1/2 for EMPTY/ONE/FULL.
- Latency: an entry accepted at edge N appears on out_* after edge N (one cycle). Throughput is 1 entry/cycle when out_ready_i=1. Entries leave strictly in arrival order.
- A held entry is stable: out_data_o/out_ctrl_o do not change while out_valid_o=1 and out_ready_i=0.
- Bubble: out_ctrl_o=0 when out_valid_o=0. out_data_o=0 as well if CLEAR_DATA=1.
- Flush: flush_i=1 at an edge forces EMPTY.
  - Main and skid are invalidated, ctrl is cleared, and data is cleared if CLEAR_DATA=1.
  - Any push or pop in the same cycle is discarded; the push is not captured.
  - in_ready_o=1 on the following cycle.
- Reset (rst_n=0, asynchronous, any time, including mid-transfer): state EMPTY, with the following values:
  - out_valid_o=0, out_data_o=0, out_ctrl_o=0, occupancy_o=0, in_ready_o=1.
  - Skid contents = 0.
- Upstream may drop in_valid_i or change in_data_i while in_ready_o=0 without effect.
- Illegal encoding (unused state value) recovers to EMPTY on the next edge.

Decomposition:
- Shared package pipe_pkg: state localparams (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2) and the EX/MEM control-bundle bit positions and width constant, so stage instantiators pack and unpack identically.
- No sub-module: single module with one state register plus main and skid registers.

Test Plan:
1. Reset -> out_valid_o=0, out_ctrl_o=0, out_data_o=0, occupancy_o=0, in_ready_o=1; reassert rst_n=0 mid-stream with 2 entries held -> all cleared immediately, without waiting for a clock edge.
2. Streaming, out_ready_i=1, push data 0x8, 0x14, 0x18 on consecutive cycles with ctrl 0x201, 0x010, 0x207 -> each appears one cycle later in order; occupancy_o stays 1; no stall.
3. Back-pressure: push 0xA then 0xB with out_ready_i=0 -> occupancy 2, in_ready_o=0, out_data_o=0xA stable; offering 0xC is ignored; raise out_ready_i -> 0xA, then 0xB, then occupancy 0.
4. Simultaneous push+pop in ONE (main=0x20, push 0x2C) -> out_data_o=0x2C next cycle, occupancy_o stays 1.
5. Flush in FULL while pushing 0xEEEEEEEE with ctrl all-ones -> next cycle out_valid_o=0, out_ctrl_o=0, out_data_o=0, occupancy_o=0, in_ready_o=1; push 0xDDDDDDDD with flush_i=0 -> appears one cycle later.
6. CLEAR_DATA=0 build: flush with main=0x1234 -> out_valid_o=0, out_ctrl_o=0, out_data_o remains 0x1234.
